// File: rtl/iir_sample_host.sv
`default_nettype none
// ============================================================================
// Module      : iir_sample_host
// Description : Sample-memory responder for an IIR filter. It buffers an input
//               frame, serves filter reads and captures filter writes, then
//               streams the results out. Optional checksum: IIR_HOST_CKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_sample_host #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [15:0]   s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [15:0]   m_data,
  output logic          filt_rst,
  input  logic          load,
  input  logic [19:0]   RAddr,
  output logic [15:0]   DIn,
  input  logic          WEN,
  input  logic [19:0]   WAddr,
  input  logic [15:0]   Yn,
  output logic          data_done,
  output logic [15:0]   cksum
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);

  state_t      state_q, state_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] wr_cnt_q, wr_cnt_d;
  logic [AW:0] rd_cnt_q, rd_cnt_d;
  logic        zdone_q, zdone_d;

  logic [15:0] in_buf  [DEPTH];
  logic [15:0] out_buf [DEPTH];

  logic [19:0] len_ext;
  logic        s_fire;
  logic        m_fire;
  logic        raddr_end;
  logic        out_we;
  logic        frame_start;

  assign len_ext     = {{(19-AW){1'b0}}, len_q};
  assign s_fire      = (state_q == S_LOAD) && s_valid;
  assign m_fire      = (state_q == S_DRAIN) && m_ready;
  assign raddr_end   = (RAddr == len_ext);
  // The final write (WAddr = L-1) coincides with the RAddr == L cycle, still in RUN.
  assign out_we      = (state_q == S_RUN) && WEN && (WAddr < len_ext);
  assign frame_start = (state_q == S_IDLE) && start && (len != '0);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    zdone_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            zdone_d = 1'b1;
          end else begin
            len_d    = (len > C_DEPTH) ? C_DEPTH : len;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            state_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (s_fire) begin
          wr_cnt_d = wr_cnt_q + C_ONE;
          if (wr_cnt_q + C_ONE == len_q) state_d = S_ARM;
        end
      end
      S_ARM:   state_d = S_RUN;
      S_RUN:   if (raddr_end) state_d = S_DRAIN;
      S_DRAIN: begin
        if (m_fire) begin
          rd_cnt_d = rd_cnt_q + C_ONE;
          if (rd_cnt_q + C_ONE == len_q) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      zdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      zdone_q  <= zdone_d;
    end
  end

  // Buffer contents survive reset; only the control state is cleared.
  always_ff @(posedge clk) begin
    if (s_fire) in_buf[wr_cnt_q[AW-1:0]] <= s_data;
    if (out_we) out_buf[WAddr[AW-1:0]]   <= Yn;
  end

  assign busy      = (state_q != S_IDLE);
  assign s_ready   = (state_q == S_LOAD);
  assign filt_rst  = (state_q == S_ARM);
  assign m_valid   = (state_q == S_DRAIN);
  assign m_data    = (state_q == S_DRAIN) ? out_buf[rd_cnt_q[AW-1:0]] : 16'h0000;
  assign done      = (state_q == S_DONE) || zdone_q;
  assign data_done = ((state_q == S_RUN) && raddr_end) ||
                     (state_q == S_DRAIN) || (state_q == S_DONE);
  assign DIn       = ((state_q == S_RUN) && load && (RAddr < len_ext)) ?
                     in_buf[RAddr[AW-1:0]] : 16'h0000;

`ifdef IIR_HOST_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (frame_start)  cksum_d = 16'h0000;
    else if (m_fire)  cksum_d = cksum_q + m_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cksum_q <= 16'h0000;
    else      cksum_q <= cksum_d;
  end

  assign cksum = cksum_q;
`else
  assign cksum = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/iir_sample_host.md
Name: iir_sample_host

Overview:
Memory-side responder for the IIR filter's sample interface. It services the filter's RAddr/load read requests with DIn, captures Yn at WAddr when WEN is high, and asserts data_done at end of frame. Input frames arrive on a valid/ready stream into an internal sample buffer. Filtered results are returned on an output valid/ready stream. It also sequences the filter's reset between frames.

Parameters:
DEPTH, 256, sample/result buffer depth in 16-bit words (power of 2)
AW, 8, log2(DEPTH)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  one-cycle frame start; sampled only in IDLE
len  input  AW+1  frame length in samples, latched on start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when a frame completes
s_valid  input  1  input sample valid
s_ready  output  1  input sample ready
s_data  input  16  input sample, two's complement
m_valid  output  1  result valid
m_ready  input  1  result ready
m_data  output  16  result, two's complement
filt_rst  output  1  active-high reset to the filter
load  input  1  filter read enable
RAddr  input  20  filter read address
DIn  output  16  sample returned to the filter
WEN  input  1  filter write enable
WAddr  input  20  filter write address
Yn  input  16  filter output sample
data_done  output  1  end-of-frame indication to the filter
cksum  output  16  result checksum (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state IDLE; all counters and pointers 0; s_ready, m_valid, busy, done, filt_rst, data_done, cksum = 0. Buffer contents are not cleared.
- States and transitions:
  - IDLE: on start with len==0, emit a done pulse the next cycle and stay in IDLE. On start with len>0, latch L = min(len, DEPTH) and go to LOAD.
  - LOAD: s_ready=1. Each s_valid&s_ready writes in_buf[wr_cnt] and increments wr_cnt. After the L-th accept, go to ARM. Gaps in s_valid are allowed.
  - ARM: exactly one cycle with filt_rst=1, then RUN.
  - RUN: filter reads and writes are serviced (rules below). When RAddr==L, go to DRAIN next cycle.
  - DRAIN: m_valid=1 and m_data=out_buf[rd_cnt], both stable while m_ready=0. Each m_valid&m_ready increments rd_cnt. After the L-th transfer, go to DONE.
  - DONE: one cycle with done=1, then IDLE.
- Read service:
  - DIn = in_buf[RAddr[AW-1:0]], combinational and same cycle, when state==RUN, load=1 and RAddr<L.
  - Otherwise DIn=0.
- Write capture:
  - In RUN or DRAIN-entry cycles, WEN=1 with WAddr<L writes out_buf[WAddr] <= Yn.
  - Writes with WAddr>=L, or in any other state, are ignored.
- data_done: combinational 1 when state==RUN and RAddr==L, and held 1 throughout DRAIN and DONE. The last filter write (WAddr=L-1) lands in the RAddr==L cycle and must be captured.
- start outside IDLE is ignored; len changes after latch are ignored.
- Reset mid-operation aborts the frame immediately. There is no done pulse and no partial drain.

Optional Feature:
IIR_HOST_CKSUM_EN
- Defined: cksum is a 16-bit running sum, modulo 2^16, of every accepted m_data. It clears on entry to LOAD and holds its value after DONE.
- Undefined: cksum is tied to 0 and no adder is built.

Test Plan:
- len=4; stream 0x1000,0x2000,0x3000,0x4000; behavioural filter drives RAddr 0..4 and WEN with Yn=0x0011..0x0044 at WAddr 0..3 -> DIn follows in_buf per address; data_done=1 exactly when RAddr=4; m_data 0x0011,0x0022,0x0033,0x0044 in order; done pulses once.
- Same frame with m_ready toggling 1,0,0,1 -> no result dropped or duplicated; m_data stable while m_ready=0.
- LOAD with s_valid gaps (1,0,1,0,1,1) and len=4 -> exactly 4 samples accepted; ARM holds filt_rst=1 for one cycle.
- start with len=0 -> done pulse next cycle; s_ready never asserted; busy stays 0.
- RAddr=6 or load=0 in RUN with L=4 -> DIn=0; WEN at WAddr=5 leaves out_buf unchanged.
- rst=0 asserted mid-RUN -> all outputs 0 asynchronously; a new start after release runs a clean frame; with IIR_HOST_CKSUM_EN, the 4-result frame above gives cksum=0x00AA.
